ws2812_receiver: RTL and testbench

WS2812_RECEIVER -- requirements
Module: ws2812_receiver

---
 rtl/ws2812_receiver.sv | 205 ++++++++++++++++++++
 tb/tb_ws2812_receiver.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_receiver.sv
// WS2812 serial line receiver: decodes pulse-width bits into 24-bit GRB pixels and frame strobes.
// Define WS2812_RX_CHECK_EN to enable pulse-length and partial-word error detection.
module ws2812_receiver #(
  parameter int unsigned THRESH_CYCLES   = 8,
  parameter int unsigned MIN_HIGH_CYCLES = 2,
  parameter int unsigned MAX_HIGH_CYCLES = 14,
  parameter int unsigned LATCH_CYCLES    = 600,
  parameter int unsigned NUM_PIXELS      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic        pixel_valid,
  output logic [23:0] pixel_data,
  output logic [5:0]  pixel_index,
  output logic        frame_done,
  output logic [6:0]  pixel_count,
  output logic        error
);

`ifdef WS2812_RX_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  localparam int unsigned HW = $clog2(MAX_HIGH_CYCLES + 2);
  localparam int unsigned LW = $clog2(LATCH_CYCLES + 1);

  typedef enum logic [1:0] {StWaitLatch, StReady, StHigh, StLow} state_e;

  state_e state_q, state_d;

  logic          sync_q, din_s, din_prev;
  logic [HW-1:0] high_cnt_q, high_cnt_d, high_inc;
  logic [LW-1:0] low_cnt_q, low_cnt_d, low_inc;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic          bits_seen_q, bits_seen_d;
  logic          word_done_q, word_done_d;
  logic [6:0]    cap_cnt_q, cap_cnt_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [23:0]   pixel_data_q, pixel_data_d;
  logic [5:0]    pixel_index_q, pixel_index_d;
  logic          frame_done_q, frame_done_d;
  logic [6:0]    pixel_count_q, pixel_count_d;
  logic          error_q, error_d;

  logic rise, high_fall, bit_ev, bit_val;
  logic short_err, long_err, latch_ev, part_err, err_ev;
  logic frame_end, discard, strobe;

  // Both counters saturate so a stuck line can never wrap back into a legal-looking value.
  assign high_inc = (high_cnt_q == HW'(MAX_HIGH_CYCLES + 1)) ? high_cnt_q : high_cnt_q + HW'(1);
  assign low_inc  = (low_cnt_q == LW'(LATCH_CYCLES)) ? low_cnt_q : low_cnt_q + LW'(1);

  assign rise      = din_s & ~din_prev;
  assign high_fall = (state_q == StHigh) && !din_s;
  assign bit_val   = high_cnt_q >= HW'(THRESH_CYCLES);
  assign short_err = CheckEn && high_fall && (high_cnt_q < HW'(MIN_HIGH_CYCLES));
  // Fires on the first cycle the pulse is longer than allowed, not at its falling edge.
  assign long_err  = CheckEn && (state_q == StHigh) && din_s &&
                     (high_cnt_q >= HW'(MAX_HIGH_CYCLES));
  assign bit_ev    = high_fall && !short_err;
  assign latch_ev  = (state_q == StLow) && !din_s && (low_inc == LW'(LATCH_CYCLES));
  assign part_err  = CheckEn && latch_ev && (bit_cnt_q != 5'd0);
  assign err_ev    = short_err | long_err | part_err;
  assign frame_end = latch_ev && bits_seen_q && !err_ev;
  assign discard   = latch_ev | err_ev;
  assign strobe    = word_done_q && (cap_cnt_q < 7'(NUM_PIXELS)) && !err_ev && !frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWaitLatch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitLatch: if (!din_s && low_inc == LW'(LATCH_CYCLES)) state_d = StReady;
      StReady:     if (rise) state_d = StHigh;
      StHigh: begin
        if (err_ev) state_d = StWaitLatch;
        else if (!din_s) state_d = StLow;
      end
      StLow: begin
        if (rise) state_d = StHigh;
        else if (latch_ev) state_d = part_err ? StWaitLatch : StReady;
      end
      default: state_d = StWaitLatch;
    endcase
  end

  always_comb begin
    high_cnt_d    = '0;
    low_cnt_d     = '0;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    bits_seen_d   = bits_seen_q;
    word_done_d   = 1'b0;
    cap_cnt_d     = cap_cnt_q;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    pixel_count_d = pixel_count_q;

    unique case (state_q)
      StWaitLatch: low_cnt_d = din_s ? '0 : low_inc;
      StReady:     if (rise) high_cnt_d = HW'(1);
      StHigh: begin
        if (din_s) high_cnt_d = high_inc;
        else low_cnt_d = LW'(1);
      end
      StLow: begin
        if (rise) high_cnt_d = HW'(1);
        else low_cnt_d = low_inc;
      end
      default: ;
    endcase

    if (bit_ev) begin
      shift_d     = {shift_q[22:0], bit_val};
      bits_seen_d = 1'b1;
      if (bit_cnt_q == 5'd23) begin
        bit_cnt_d   = 5'd0;
        word_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    if (strobe) begin
      pixel_data_d = shift_q;
      cap_cnt_d    = cap_cnt_q + 7'd1;
    end
    if (pixel_valid_q) pixel_index_d = pixel_index_q + 6'd1;
    if (frame_end) pixel_count_d = cap_cnt_q;

    // An error restarts the latch search from zero so a fresh full-length low is required.
    if (err_ev) begin
      high_cnt_d = '0;
      low_cnt_d  = '0;
    end
    if (discard) begin
      shift_d       = '0;
      bit_cnt_d     = 5'd0;
      bits_seen_d   = 1'b0;
      word_done_d   = 1'b0;
      cap_cnt_d     = 7'd0;
      pixel_index_d = 6'd0;
    end

    pixel_valid_d = strobe;
    frame_done_d  = frame_end;
    error_d       = err_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= 1'b0;
      din_s         <= 1'b0;
      din_prev      <= 1'b0;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= 5'd0;
      bits_seen_q   <= 1'b0;
      word_done_q   <= 1'b0;
      cap_cnt_q     <= 7'd0;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      pixel_index_q <= 6'd0;
      frame_done_q  <= 1'b0;
      pixel_count_q <= 7'd0;
      error_q       <= 1'b0;
    end else begin
      sync_q        <= din;
      din_s         <= sync_q;
      din_prev      <= din_s;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      bits_seen_q   <= bits_seen_d;
      word_done_q   <= word_done_d;
      cap_cnt_q     <= cap_cnt_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      pixel_count_q <= pixel_count_d;
      error_q       <= error_d;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel_data  = pixel_data_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign pixel_count = pixel_count_q;
  assign error       = CheckEn ? error_q : 1'b0;

endmodule

// File: tb/tb_ws2812_receiver.sv
// Self-checking bench for ws2812_receiver: table vectors, directed corner cases and random frames
// checked against a pulse-list reference model.
module tb_ws2812_receiver;

`ifdef WS2812_RX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int THRESH = 8;
  localparam int MINH   = 2;
  localparam int MAXH   = 14;
  localparam int NPIX   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [5:0]  pixel_index;
  logic        frame_done;
  logic [6:0]  pixel_count;
  logic        error;

  ws2812_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .pixel_valid(pixel_valid),
    .pixel_data (pixel_data),
    .pixel_index(pixel_index),
    .frame_done (frame_done),
    .pixel_count(pixel_count),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    int          idx;
    int          cyc;
  } pix_t;

  typedef struct {
    logic [23:0] word;
    int          nbits;
    int          one_hi;
    int          one_lo;
    int          zero_hi;
    int          zero_lo;
    int          exp_pix;
    logic [23:0] exp_data;
    int          exp_done;
    int          exp_count;
    int          exp_err;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  pix_t got_pix[$];
  int   got_done[$];
  int   got_err  = 0;
  int   overlap  = 0;

  int   hi_q[$];
  int   lo_q[$];
  int   fall_q[$];
  pix_t exp_pix[$];
  int   exp_done, exp_count, exp_err;
  int   last_count = 0;
  int   b_pix, b_done, b_err;
  vec_t vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_valid) got_pix.push_back(pix_t'{pixel_data, int'(pixel_index), cyc});
      if (frame_done) got_done.push_back(int'(pixel_count));
      if (error) got_err++;
      if (int'(pixel_valid) + int'(frame_done) + int'(error) > 1) overlap++;
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic push_word(input logic [23:0] w, input int nbits, input int oh, input int ol,
                           input int zh, input int zl);
    for (int k = 0; k < nbits; k++) begin
      if (w[23 - (k % 24)]) begin
        hi_q.push_back(oh);
        lo_q.push_back(ol);
      end else begin
        hi_q.push_back(zh);
        lo_q.push_back(zl);
      end
    end
  endtask

  // Called at a negedge; din changes there and is first sampled at the next posedge.
  task automatic drive_pulses();
    fall_q.delete();
    for (int i = 0; i < hi_q.size(); i++) begin
      din = 1'b1;
      repeat (hi_q[i]) @(negedge clk);
      din = 1'b0;
      fall_q.push_back(cyc);
      repeat (lo_q[i]) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int trail);
    b_pix  = got_pix.size();
    b_done = got_done.size();
    b_err  = got_err;
    drive_pulses();
    din = 1'b0;
    repeat (trail) @(negedge clk);
  endtask

  // Reference: each pulse is one bit (high length vs threshold), 24 bits make a word, the pixel
  // strobe appears 4 bench cycles after the negedge that dropped din for the 24th bit.
  task automatic model(input bit armed);
    int bits, words, total;
    logic [23:0] sh;
    bit bad;
    bits = 0; words = 0; total = 0; sh = '0; bad = 1'b0;
    exp_pix.delete();
    if (armed) begin
      for (int i = 0; i < hi_q.size(); i++) begin
        if (CHK && (hi_q[i] < MINH || hi_q[i] > MAXH)) begin
          bad = 1'b1;
          break;
        end
        sh = {sh[22:0], hi_q[i] >= THRESH};
        total++;
        bits++;
        if (bits == 24) begin
          if (words < NPIX) exp_pix.push_back(pix_t'{sh, words, fall_q[i] + 4});
          words++;
          bits = 0;
        end
      end
    end
    exp_err   = (bad || (CHK && bits != 0)) ? 1 : 0;
    exp_done  = (exp_err == 0 && total > 0) ? 1 : 0;
    exp_count = (words < NPIX) ? words : NPIX;
  endtask

  task automatic compare(input string tag);
    int npix, ndone;
    npix  = got_pix.size() - b_pix;
    ndone = got_done.size() - b_done;
    check({tag, " pixel_valid count"}, npix, exp_pix.size());
    for (int j = 0; j < exp_pix.size() && j < npix; j++) begin
      check($sformatf("%s pixel_data[%0d]", tag, j), got_pix[b_pix + j].data, exp_pix[j].data);
      check($sformatf("%s pixel_index[%0d]", tag, j), got_pix[b_pix + j].idx, exp_pix[j].idx);
      check($sformatf("%s pixel_valid cycle[%0d]", tag, j), got_pix[b_pix + j].cyc,
            exp_pix[j].cyc);
    end
    check({tag, " frame_done count"}, ndone, exp_done);
    if (exp_done == 1 && ndone == 1)
      check({tag, " pixel_count at frame_done"}, got_done[b_done], exp_count);
    check({tag, " error count"}, got_err - b_err, exp_err);
    if (exp_done == 1) last_count = exp_count;
    check({tag, " pixel_count held"}, pixel_count, last_count);
    hi_q.delete();
    lo_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, " pixel_valid"}, pixel_valid, 0);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " error"}, error, 0);
    check({tag, " pixel_data"}, pixel_data, 0);
    check({tag, " pixel_index"}, pixel_index, 0);
    check({tag, " pixel_count"}, pixel_count, 0);
  endtask

  initial begin
    vecs[0] = '{24'hFF0055, 24, 10, 5, 5, 10, 1, 24'hFF0055, 1, 1, 0};
    vecs[1] = '{24'hA5A5A5, 24, 8, 3, 7, 3, 1, 24'hA5A5A5, 1, 1, 0};
    vecs[2] = '{24'h123456, 24, 14, 1, 2, 1, 1, 24'h123456, 1, 1, 0};
    vecs[3] = '{24'hABC000, 12, 10, 5, 5, 10, 0, 24'h000000, CHK ? 0 : 1, 0, CHK ? 1 : 0};
    vecs[4] = '{24'h00FF81, 48, 10, 5, 5, 10, 2, 24'h00FF81, 1, 2, 0};

    rst = 1'b1;
    din = 1'b0;
    repeat (4) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Pulses straight after reset must be ignored until a full latch low has been seen.
    push_word(24'hFF0055, 24, 10, 5, 5, 10);
    run_frame(650);
    model(1'b0);
    compare("pre-latch");

    for (int i = 0; i < 5; i++) begin
      push_word(vecs[i].word, vecs[i].nbits, vecs[i].one_hi, vecs[i].one_lo, vecs[i].zero_hi,
                vecs[i].zero_lo);
      run_frame((CHK && (vecs[i].nbits % 24) != 0) ? 1300 : 650);
      exp_pix.delete();
      for (int j = 0; j < vecs[i].exp_pix; j++)
        exp_pix.push_back(pix_t'{vecs[i].exp_data, j, fall_q[24 * j + 23] + 4});
      exp_done  = vecs[i].exp_done;
      exp_count = vecs[i].exp_count;
      exp_err   = vecs[i].exp_err;
      compare($sformatf("vec%0d", i));
    end

    // Over-long high pulse in bit 5, then a clean frame.
    push_word(24'hFF0055, 24, 10, 5, 5, 10);
    hi_q[5] = 20;
    run_frame(650);
    model(1'b1);
    compare("long-pulse");
    push_word(24'h5A3C96, 24, 10, 5, 5, 10);
    run_frame(650);
    model(1'b1);
    compare("after-long");

    for (int p = 0; p < 64; p++) push_word({8'(p), 8'(p), 8'(p)}, 24, 9, 2, 3, 2);
    run_frame(650);
    model(1'b1);
    compare("ramp64");
    for (int p = 0; p < 66; p++) push_word({8'(p), 8'(255 - p), 8'(p)}, 24, 9, 2, 3, 2);
    run_frame(650);
    model(1'b1);
    compare("ramp66");

    for (int f = 0; f < 6; f++) begin
      int npix, extra;
      npix  = int'($urandom_range(3, 1));
      extra = ($urandom_range(2, 0) == 0) ? int'($urandom_range(23, 1)) : 0;
      for (int k = 0; k < npix * 24 + extra; k++) begin
        hi_q.push_back(CHK ? int'($urandom_range(MAXH, MINH)) : int'($urandom_range(20, 1)));
        lo_q.push_back(int'($urandom_range(12, 1)));
      end
      run_frame((CHK && extra != 0) ? 1300 : 650);
      model(1'b1);
      compare($sformatf("rand%0d", f));
    end

    // Reset in the middle of a pixel.
    push_word(24'hC3A5F0, 10, 10, 5, 5, 10);
    drive_pulses();
    hi_q.delete();
    lo_q.delete();
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("mid-reset");
    rst = 1'b0;
    last_count = 0;
    push_word(24'h0F1E2D, 24, 10, 5, 5, 10);
    run_frame(650);
    model(1'b0);
    compare("post-reset ignored");
    push_word(24'h0F1E2D, 24, 10, 5, 5, 10);
    run_frame(650);
    model(1'b1);
    compare("post-reset decode");

    check("exclusive strobes", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
